square_calculator: RTL and testbench
====================================

SQUARE_CALCULATOR -- requirements
Module: square_calculator

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand width; the result is 2*WIDTH bits.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port start, input, 1, request to square value; sampled only in IDLE.
REQ-005 SHALL provide port value, input, WIDTH, operand to square; captured on the edge that accepts start.
REQ-006 SHALL provide port busy, output, 1, registered; high while a request is in progress (states CALC and DONE).
REQ-007 SHALL provide port done, output, 1, registered single-cycle completion pulse.
REQ-008 SHALL provide port square, output, 2*WIDTH, registered result value*value.

Function
REQ-009 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-010 SHALL follow IDLE->CALC on a rising edge with start=1, CALC->DONE after WIDTH iterations, and DONE->IDLE unconditionally on the next edge.
REQ-011 SHALL, on the accepting edge, capture value into a multiplicand register and a shift register, clear the accumulator, and clear the iteration counter.
REQ-012 SHALL perform exactly one shift-add iteration per CALC cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; then shift the multiplicand left by 1 and the multiplier right by 1.
REQ-013 SHALL keep the accumulator and shifted multiplicand at 2*WIDTH bits so that no intermediate overflow or truncation occurs.
REQ-014 SHALL load square from the final accumulator on the edge entering DONE, and assert done=1 for exactly the DONE cycle.
REQ-015 SHALL make latency fixed: done goes high WIDTH rising edges after the edge that accepted start (16 for the default), independent of operand value.
REQ-016 SHALL hold square at its last result until the next DONE entry; square SHALL NOT change during CALC.
REQ-017 SHALL ignore start while busy=1, including in the DONE cycle; value changes during CALC SHALL have no effect.
REQ-018 SHALL accept a start asserted in the first IDLE cycle after DONE, giving back-to-back operation at a throughput of one result per WIDTH+2 cycles.
REQ-019 SHALL produce square=0 for value=0 and 2^(2*WIDTH)-2^(WIDTH+1)+1 for value=all-ones, with no saturation.

Reset
REQ-020 SHALL, on rst high, go immediately to IDLE regardless of clk, with busy=0, done=0, square=0, accumulator and counter cleared.
REQ-021 SHALL, on reset mid-CALC, abandon the operation: no done pulse, and square remains 0 after reset release.
REQ-022 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-023 SHALL place the state encodings (IDLE, CALC, DONE as 2-bit constants) and the default WIDTH in the shared project package used with sqrt_calculator.
REQ-024 SHALL be a single module with no sub-modules; the FSM and the shift-add datapath are co-located, with one registered process for state/datapath and combinational next-state logic.
REQ-025 SHALL use no divider or multiplier operator; the datapath is an adder, shifters and a log2(WIDTH)+1-bit counter only.

Verification
REQ-026 Bench SHALL cover: value=3, start pulse -> done pulse 16 edges later, square=9, busy high for 17 cycles.
REQ-027 Bench SHALL cover: value=16'hFFFF -> square=32'hFFFE0001; value=0 -> square=0, with the same latency.
REQ-028 Bench SHALL cover: start=1 held continuously with value=5 then value=7 presented at the next acceptance -> results 25 then 49, each accepted in the IDLE cycle after done, with value changes mid-CALC ignored.
REQ-029 Bench SHALL cover: start pulses during CALC and DONE -> no extra operation, exactly one done pulse per accepted start.
REQ-030 Bench SHALL cover: rst asserted asynchronously at iteration 8 with value=100 -> busy/done/square go to 0 immediately, no done pulse, next start with value=12 -> square=144.
REQ-031 Bench SHALL cover: a random sweep of 1000 operands -> square equals the reference product every time, cross-checked against sqrt_calculator, whose root of square returns value.

Source files
------------

// File: rtl/square_calculator_pkg.sv
// Shared definitions for the square/sqrt calculator family: FSM encodings and default operand width.
package square_calculator_pkg;

  // Default operand width; results are twice this wide.
  localparam int unsigned SQ_DEFAULT_WIDTH = 16;

  // Controller state encodings shared by the calculator blocks.
  localparam logic [1:0] SQ_ENC_IDLE = 2'd0;
  localparam logic [1:0] SQ_ENC_CALC = 2'd1;
  localparam logic [1:0] SQ_ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = SQ_ENC_IDLE,
    ST_CALC = SQ_ENC_CALC,
    ST_DONE = SQ_ENC_DONE
  } sq_state_e;

  // Bits needed for an iteration counter that must reach 'width'.
  function automatic int unsigned sq_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/square_calculator.sv
// Sequential squarer: one shift-add iteration per cycle, fixed WIDTH-cycle latency.
module square_calculator
  import square_calculator_pkg::*;
#(
  parameter int unsigned WIDTH = SQ_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] square
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = sq_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  sq_state_e        state_q, state_d;
  logic [RES_W-1:0] mcand_q;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RES_W-1:0] square_q;
  logic             busy_q;
  logic             done_q;
  logic             last_iter;

  assign busy   = busy_q;
  assign done   = done_q;
  assign square = square_q;

  // Next accumulator value and next controller state.
  always_comb begin
    state_d   = state_q;
    last_iter = (cnt_q == LAST_ITER);
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, shift-add datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      square_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= RES_W'(value);
            mplier_q <= value;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Final iteration: publish the completed product as we enter DONE.
          if (last_iter) begin
            square_q <= acc_d;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_calculator.sv
// Self-checking bench for square_calculator with a plain-arithmetic reference model.
module tb_square_calculator;

  localparam int unsigned W = 16;
  localparam int unsigned LAT = 16;
  localparam int unsigned BUSY_CYC = 17;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   value;
  logic           busy;
  logic           done;
  logic [2*W-1:0] square;

  int n_checks = 0;
  int n_fail   = 0;

  square_calculator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .square(square)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product of an operand with itself.
  function automatic logic [2*W-1:0] ref_square(input logic [W-1:0] v);
    longint p;
    p = longint'(v) * longint'(v);
    return (2*W)'(p);
  endfunction

  // Integer square root by binary search; the root of a product must return the operand.
  function automatic longint ref_isqrt(input logic [2*W-1:0] s);
    longint lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(s)) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Runs one operation from a start request and reports what was observed.
  task automatic do_op(input logic [W-1:0] v, input bit poke_start,
                       output int lat, output logic [2*W-1:0] sq,
                       output int busy_cycles, output int done_pulses, output bit sq_changed);
    logic [2*W-1:0] sq0;
    lat = -1; sq = 'x; busy_cycles = 0; done_pulses = 0; sq_changed = 1'b0;
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    sq0 = square;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i > 0 && i < int'(LAT) && square !== sq0) sq_changed = 1'b1;
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (lat < 0) begin
          lat = i;
          sq  = square;
        end
      end
      if (busy !== 1'b1) break;
      value = W'($urandom);
      start = poke_start ? 1'($urandom) : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; value = '0;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (square !== '0) begin n_fail++; $display("FAIL reset_square got=%h want=0", square); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc, dp; logic [2*W-1:0] sq; bit ch;
    do_op(16'd3, 1'b0, lat, sq, bc, dp, ch);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL basic_latency got=%0d want=16", lat); end
    n_checks++; if (sq !== 32'd9) begin n_fail++; $display("FAIL basic_square got=%0d want=9", sq); end
    n_checks++; if (bc !== int'(BUSY_CYC)) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, BUSY_CYC); end
    n_checks++; if (dp !== 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d want=1", dp); end
    n_checks++; if (ch !== 1'b0) begin n_fail++; $display("FAIL basic_square_stable got=%b want=0", ch); end
  endtask

  task automatic test_extremes();
    int lat, bc, dp; logic [2*W-1:0] sq; bit ch;
    do_op(16'hFFFF, 1'b0, lat, sq, bc, dp, ch);
    n_checks++; if (sq !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_square got=%h want=fffe0001", sq); end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL max_latency got=%0d want=16", lat); end
    do_op(16'h0000, 1'b0, lat, sq, bc, dp, ch);
    n_checks++; if (sq !== 32'h0) begin n_fail++; $display("FAIL zero_square got=%h want=0", sq); end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL zero_latency got=%0d want=16", lat); end
    n_checks++; if (ch !== 1'b0) begin n_fail++; $display("FAIL zero_square_stable got=%b want=0", ch); end
  endtask

  task automatic test_back_to_back();
    int t1, t2; logic [2*W-1:0] s1, s2; logic b17, b18;
    t1 = -1; t2 = -1; s1 = 'x; s2 = 'x; b17 = 1'bx; b18 = 1'bx;
    start = 1'b1;
    value = 16'd5;
    @(posedge clk); #1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (k == 17) b17 = busy;
      if (k == 18) b18 = busy;
      if (done) begin
        if (t1 < 0) begin t1 = k; s1 = square; end
        else if (t2 < 0) begin t2 = k; s2 = square; end
      end
      if (t2 >= 0) begin
        start = 1'b0;
        break;
      end
      if (t1 >= 0 && k >= t1) value = 16'd7;
      else value = W'($urandom);
    end
    start = 1'b0;
    n_checks++; if (t1 !== 16) begin n_fail++; $display("FAIL b2b_first_done_edge got=%0d want=16", t1); end
    n_checks++; if (s1 !== 32'd25) begin n_fail++; $display("FAIL b2b_first_square got=%0d want=25", s1); end
    n_checks++; if (b17 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap_busy got=%b want=0", b17); end
    n_checks++; if (b18 !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept_busy got=%b want=1", b18); end
    n_checks++; if (t2 !== 34) begin n_fail++; $display("FAIL b2b_second_done_edge got=%0d want=34", t2); end
    n_checks++; if (s2 !== 32'd49) begin n_fail++; $display("FAIL b2b_second_square got=%0d want=49", s2); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int lat, bc, dp, extra; logic [2*W-1:0] sq; bit ch;
    do_op(16'd1234, 1'b1, lat, sq, bc, dp, ch);
    n_checks++; if (sq !== ref_square(16'd1234)) begin n_fail++; $display("FAIL ign_square got=%0d want=%0d", sq, ref_square(16'd1234)); end
    n_checks++; if (dp !== 1) begin n_fail++; $display("FAIL ign_done_pulses got=%0d want=1", dp); end
    n_checks++; if (bc !== int'(BUSY_CYC)) begin n_fail++; $display("FAIL ign_busy_cycles got=%0d want=%0d", bc, BUSY_CYC); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ign_extra_activity got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bc, dp, nd; logic [2*W-1:0] sq; bit ch;
    start = 1'b1;
    value = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b want=0", done); end
    n_checks++; if (square !== '0) begin n_fail++; $display("FAIL rstmid_square got=%h want=0", square); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d want=0", nd); end
    n_checks++; if (square !== '0) begin n_fail++; $display("FAIL rstmid_square_after got=%h want=0", square); end
    // Operation requested immediately after a reset release.
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'd12, 1'b0, lat, sq, bc, dp, ch);
    n_checks++; if (sq !== 32'd144) begin n_fail++; $display("FAIL rstmid_next_square got=%0d want=144", sq); end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL rstmid_next_latency got=%0d want=16", lat); end
  endtask

  task automatic test_random_sweep();
    int lat, bc, dp; logic [2*W-1:0] sq; bit ch; logic [W-1:0] v;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0:       v = '0;
        1:       v = '1;
        default: v = W'($urandom);
      endcase
      do_op(v, 1'($urandom), lat, sq, bc, dp, ch);
      n_checks++; if (sq !== ref_square(v)) begin n_fail++; $display("FAIL sweep_square v=%0d got=%0d want=%0d", v, sq, ref_square(v)); end
      n_checks++; if (ref_isqrt(sq) !== longint'(v)) begin n_fail++; $display("FAIL sweep_root v=%0d got=%0d want=%0d", v, ref_isqrt(sq), v); end
      n_checks++; if (lat !== 16 || dp !== 1) begin n_fail++; $display("FAIL sweep_timing v=%0d got=lat%0d/pulses%0d want=lat16/pulses1", v, lat, dp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_calc();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
